// File: rtl/encryption_arbiter.sv
// Tag FIFO: in-order record of which requester issued each block in flight.
// Latency: push visible at head one cycle after the write; head is read combinationally.
// Backpressure: writes are ignored when full and reads are ignored when empty.
module fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok  = wr_vld && (count != FULL_C);
  assign rd_ok  = rd_rdy && (count != '0);
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Round-robin share of one encryption core between two requesters, results routed back by tag.
// Latency: grant to core_s_tvalid is 1 cycle; core result to m*_axis_tvalid is combinational.
// Backpressure: grants stop when the holding register is busy or TAG_DEPTH blocks are in flight; returns are in-order head-of-line.
module encryption_arbiter #(
  parameter int TAG_DEPTH = 8,
  parameter int DATA_W    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [$clog2(TAG_DEPTH):0] inflight,
  output logic                       err_orphan,
  input  logic [DATA_W-1:0]          s0_axis_tdata,
  input  logic                       s0_axis_tvalid,
  output logic                       s0_axis_tready,
  input  logic [DATA_W-1:0]          s1_axis_tdata,
  input  logic                       s1_axis_tvalid,
  output logic                       s1_axis_tready,
  output logic [DATA_W-1:0]          m0_axis_tdata,
  output logic                       m0_axis_tvalid,
  input  logic                       m0_axis_tready,
  output logic [DATA_W-1:0]          m1_axis_tdata,
  output logic                       m1_axis_tvalid,
  input  logic                       m1_axis_tready,
  output logic [DATA_W-1:0]          core_s_tdata,
  output logic                       core_s_tvalid,
  input  logic                       core_s_tready,
  input  logic [DATA_W-1:0]          core_m_tdata,
  input  logic                       core_m_tvalid,
  output logic                       core_m_tready
);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

  logic              hold_vld;
  logic [DATA_W-1:0] hold_dat;
  logic              last;
  logic              grant;
  logic              free;
  logic              can_issue;
  logic              s_hs;
  logic              core_s_hs;
  logic              tag_vld;
  logic              head_tag;
  logic              ret_rdy;
  logic              ret_hs;

  assign core_s_tdata  = hold_dat;
  assign core_s_tvalid = hold_vld;
  assign core_s_hs     = hold_vld && core_s_tready;
  assign free          = !hold_vld || core_s_hs;
  assign can_issue     = free && (inflight < DEPTH_C);

  // Grant choice: the lone valid requester wins, otherwise whoever did not win last.
  always_comb begin
    grant = ~last;
    if (s0_axis_tvalid && !s1_axis_tvalid) grant = 1'b0;
    else if (s1_axis_tvalid && !s0_axis_tvalid) grant = 1'b1;
  end

  assign s0_axis_tready = can_issue && !grant;
  assign s1_axis_tready = can_issue && grant;
  assign s_hs = (s0_axis_tvalid && s0_axis_tready) || (s1_axis_tvalid && s1_axis_tready);

  // Return path steered by the oldest outstanding tag; results with no tag are swallowed.
  assign ret_rdy        = head_tag ? m1_axis_tready : m0_axis_tready;
  assign m0_axis_tvalid = core_m_tvalid && tag_vld && !head_tag;
  assign m1_axis_tvalid = core_m_tvalid && tag_vld && head_tag;
  assign m0_axis_tdata  = core_m_tdata;
  assign m1_axis_tdata  = core_m_tdata;
  assign core_m_tready  = tag_vld ? ret_rdy : 1'b1;
  assign ret_hs         = core_m_tvalid && tag_vld && ret_rdy;

  // Occupancy of the tag FIFO is exactly the number of blocks in flight.
  fifo #(.DEPTH(TAG_DEPTH), .W(1)) u_tag_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (s_hs),
    .wr_dat (grant),
    .rd_rdy (ret_hs),
    .rd_vld (tag_vld),
    .rd_dat (head_tag),
    .count  (inflight)
  );

  // Holding register, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld   <= 1'b0;
      hold_dat   <= '0;
      last       <= 1'b1;
      err_orphan <= 1'b0;
    end else begin
      if (s_hs) begin
        hold_vld <= 1'b1;
        hold_dat <= grant ? s1_axis_tdata : s0_axis_tdata;
        last     <= grant;
      end else if (core_s_hs) begin
        hold_vld <= 1'b0;
      end
      if (core_m_tvalid && !tag_vld) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_encryption_arbiter.sv
module tb_encryption_arbiter;
  localparam int D = 8;
  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   inflight;
  logic         err_orphan;
  logic [W-1:0] s0_axis_tdata, s1_axis_tdata, m0_axis_tdata, m1_axis_tdata;
  logic         s0_axis_tvalid, s1_axis_tvalid, s0_axis_tready, s1_axis_tready;
  logic         m0_axis_tvalid, m1_axis_tvalid, m0_axis_tready, m1_axis_tready;
  logic [W-1:0] core_s_tdata, core_m_tdata;
  logic         core_s_tvalid, core_s_tready, core_m_tvalid, core_m_tready;

  encryption_arbiter #(.TAG_DEPTH(D), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .inflight(inflight), .err_orphan(err_orphan),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
    .core_s_tdata(core_s_tdata), .core_s_tvalid(core_s_tvalid), .core_s_tready(core_s_tready),
    .core_m_tdata(core_m_tdata), .core_m_tvalid(core_m_tvalid), .core_m_tready(core_m_tready)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: outstanding blocks in issue order, and the stand-in core's output queue.
  typedef struct { bit src; logic [W-1:0] d; } tag_t;
  tag_t         tagq[$];
  logic [W-1:0] coreq[$];
  bit           mh_vld;
  logic [W-1:0] mh_dat;
  bit           mlast;
  bit           merr;
  logic [W-1:0] nxt0, nxt1;

  bit           obs0, obs1, smp_cmr, smp_m0v, smp_m1v, smp_csv, smp_s0r, smp_s1r;
  logic [W-1:0] smp_csd;
  int           del_q[$];

  typedef struct {
    bit s0v, s1v, cmv, m0r, m1r;
    bit e_s0r, e_s1r, e_cmr, e_m0v, e_m1v;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [W-1:0] enc(input logic [W-1:0] d);
    return {d[47:0], d[63:48]} ^ 64'hC3A5_5AC3_0F1E_2D3C;
  endfunction

  function automatic bit cq();
    return coreq.size() > 0;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic tick(input bit a0, input bit a1, input bit cs, input bit cm, input bit r0, input bit r1);
    bit free, can, g, e0, e1, ne, h, rhs;
    logic [W-1:0] cs_dat;
    tag_t t;
    s0_axis_tvalid = a0; s0_axis_tdata = nxt0;
    s1_axis_tvalid = a1; s1_axis_tdata = nxt1;
    core_s_tready = cs;
    core_m_tvalid = cm;
    core_m_tdata = cq() ? coreq[0] : 64'hBAD0_BAD0_BAD0_BAD0;
    m0_axis_tready = r0; m1_axis_tready = r1;
    #1;
    free = !mh_vld || cs;
    can  = free && (tagq.size() < D);
    g    = (a0 && !a1) ? 1'b0 : (a1 && !a0) ? 1'b1 : !mlast;
    e0   = can && !g;
    e1   = can && g;
    ne   = tagq.size() > 0;
    h    = ne ? tagq[0].src : 1'b0;
    rhs  = cm && ne && (h ? r1 : r0);
    chk("core_s_tvalid", core_s_tvalid, mh_vld);
    if (mh_vld) chk("core_s_tdata", core_s_tdata, mh_dat);
    chk("s0_tready", s0_axis_tready, e0);
    chk("s1_tready", s1_axis_tready, e1);
    chk("core_m_tready", core_m_tready, ne ? (h ? r1 : r0) : 1'b1);
    chk("m0_tvalid", m0_axis_tvalid, cm && ne && !h);
    chk("m1_tvalid", m1_axis_tvalid, cm && ne && h);
    if (cm && ne) chk("m_tdata", h ? m1_axis_tdata : m0_axis_tdata, enc(tagq[0].d));
    chk("inflight", inflight, tagq.size());
    chk("err_orphan", err_orphan, merr);
    obs0 = a0 && s0_axis_tready;
    obs1 = a1 && s1_axis_tready;
    smp_cmr = core_m_tready; smp_m0v = m0_axis_tvalid; smp_m1v = m1_axis_tvalid;
    smp_csv = core_s_tvalid; smp_csd = core_s_tdata;
    smp_s0r = s0_axis_tready; smp_s1r = s1_axis_tready;
    if (m0_axis_tvalid && r0) del_q.push_back(0);
    if (m1_axis_tvalid && r1) del_q.push_back(1);
    cs_dat = core_s_tdata;
    @(posedge clk);
    #1;
    if (rhs) begin
      void'(tagq.pop_front());
      if (cq()) void'(coreq.pop_front());
    end
    if (cm && !ne) merr = 1'b1;
    if (mh_vld && cs) begin
      coreq.push_back(enc(cs_dat));
      mh_vld = 1'b0;
    end
    if (a0 && e0) begin
      t.src = 1'b0; t.d = nxt0; tagq.push_back(t);
      mh_dat = nxt0; mh_vld = 1'b1; mlast = 1'b0; nxt0 = nxt0 + 1;
    end
    if (a1 && e1) begin
      t.src = 1'b1; t.d = nxt1; tagq.push_back(t);
      mh_dat = nxt1; mh_vld = 1'b1; mlast = 1'b1; nxt1 = nxt1 + 1;
    end
  endtask

  task automatic drive_idle();
    s0_axis_tvalid = 0; s1_axis_tvalid = 0; s0_axis_tdata = '0; s1_axis_tdata = '0;
    core_s_tready = 0; core_m_tvalid = 0; core_m_tdata = '0;
    m0_axis_tready = 0; m1_axis_tready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    tagq.delete(); coreq.delete();
    mh_vld = 0; mlast = 1; merr = 0;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((tagq.size() > 0 || mh_vld) && n < 60) begin
      tick(0, 0, 1, cq(), 1, 1);
      n++;
    end
    chk(name, inflight, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit prev;
    int n;
    int ones;
    logic [W-1:0] held;
    rst = 1'b1;
    drive_idle();
    nxt0 = 64'h1111_0000_0000_0000;
    nxt1 = 64'h2222_0000_0000_0000;
    mh_vld = 0; mh_dat = '0; mlast = 1; merr = 0;
    repeat (2) @(posedge clk);
    #1;

    // Combinational behaviour in the reset state (reset held so nothing moves).
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      s0_axis_tvalid = tbl[i].s0v; s1_axis_tvalid = tbl[i].s1v;
      core_m_tvalid = tbl[i].cmv;
      m0_axis_tready = tbl[i].m0r; m1_axis_tready = tbl[i].m1r;
      #2;
      chk("tbl_s0_tready", s0_axis_tready, tbl[i].e_s0r);
      chk("tbl_s1_tready", s1_axis_tready, tbl[i].e_s1r);
      chk("tbl_core_m_tready", core_m_tready, tbl[i].e_cmr);
      chk("tbl_m0_tvalid", m0_axis_tvalid, tbl[i].e_m0v);
      chk("tbl_m1_tvalid", m1_axis_tvalid, tbl[i].e_m1v);
      chk("tbl_core_s_tvalid", core_s_tvalid, 0);
      chk("tbl_inflight", inflight, 0);
      chk("tbl_err_orphan", err_orphan, 0);
    end
    do_reset();

    // Single requester: three blocks from s0, all return on m0.
    del_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 1, 0, 1, 1);
      chk("single_grant", obs0, 1);
    end
    chk("single_peak", inflight, 3);
    drain("single_drain");
    chk("single_m0_count", del_q.size(), 3);
    ones = 0;
    foreach (del_q[i]) ones += del_q[i];
    chk("single_m1_count", ones, 0);

    // Fair sharing: both continuously valid, grants and returns alternate.
    del_q.delete();
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 1, cq(), 1, 1);
      chk("fair_one_grant", obs0 ^ obs1, 1);
      if (i == 0) chk("fair_first", obs1, 1);
      else chk("fair_alternate", obs1, !prev);
      prev = obs1;
    end
    drain("fair_drain");
    chk("fair_ret_count", del_q.size(), 10);
    for (int i = 1; i < del_q.size(); i++) chk("fair_ret_alternate", del_q[i], 1 - del_q[i-1]);

    // Full: results withheld, exactly D accepted; one return frees exactly one grant.
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1, 1, 1, 0, 1, 1);
      n += int'(obs0) + int'(obs1);
    end
    chk("full_accepts", n, D);
    chk("full_inflight", inflight, D);
    tick(1, 1, 1, 0, 1, 1);
    chk("full_no_grant", obs0 | obs1, 0);
    tick(0, 0, 1, 1, 1, 1);
    tick(1, 1, 1, 0, 1, 1);
    chk("full_regrant", obs0 | obs1, 1);
    tick(1, 1, 1, 0, 1, 1);
    chk("full_one_only", obs0 | obs1, 0);
    drain("full_drain");

    // Head-of-line: m0 stalls, m1 must wait behind it.
    tick(1, 0, 1, 0, 1, 1);
    chk("hol_grant0", obs0, 1);
    tick(0, 1, 1, 0, 1, 1);
    chk("hol_grant1", obs1, 1);
    tick(0, 0, 1, 0, 1, 1);
    del_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1, 1, 0, 1);
      chk("hol_core_m_tready", smp_cmr, 0);
      chk("hol_m1_blocked", smp_m1v, 0);
    end
    drain("hol_drain");
    chk("hol_ret_count", del_q.size(), 2);
    if (del_q.size() == 2) begin
      chk("hol_first_m0", del_q[0], 0);
      chk("hol_then_m1", del_q[1], 1);
    end

    // Core backpressure: loaded block held stable, no grants.
    held = nxt0;
    tick(1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 0, 0, 1, 1);
      chk("bp_tvalid", smp_csv, 1);
      chk("bp_tdata", smp_csd, held);
      chk("bp_no_ready", smp_s0r | smp_s1r, 0);
    end
    drain("bp_drain");

    // Orphan result with nothing in flight.
    tick(0, 0, 1, 1, 1, 1);
    chk("orphan_core_m_tready", smp_cmr, 1);
    chk("orphan_no_mvalid", smp_m0v | smp_m1v, 0);
    chk("orphan_err", err_orphan, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           cq() && ($urandom_range(0, 2) != 0), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    drain("rand_drain");

    // Mid-stream reset.
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 1, 1);
    chk("pre_rst_inflight", inflight, 3);
    do_reset();
    #1;
    chk("rst_inflight", inflight, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_core_s_tvalid", core_s_tvalid, 0);
    chk("rst_mvalid", m0_axis_tvalid | m1_axis_tvalid, 0);
    tick(1, 1, 1, 0, 1, 1);
    chk("rst_first_grant_s0", obs0, 1);
    drain("rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
